// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite colour-index pipeline.
// Sprite geometry, ROM address layout and the position record.
package sprite_pkg;
  localparam int NUM_SPR = 4;
  localparam int SEL_W   = $clog2(NUM_SPR);
  localparam int SPR_DIM = 32;
  localparam int OFF_W   = $clog2(SPR_DIM);
  localparam int ROM_AW  = SEL_W + 2 * OFF_W;
  localparam int IDX_W   = 5;

  localparam logic [IDX_W-1:0] BG_IDX = 5'h00;
  localparam logic [IDX_W-1:0] TRANSP = 5'h1F;

  typedef struct packed {
    logic       en;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_pos_t;
endpackage

// File: rtl/sprite_hit.sv
// Per-sprite coverage test for the current pixel.
// Negative offsets (pixel left/above sprite) never hit; no wrap.
module sprite_hit
  import sprite_pkg::*;
(
  input  logic [9:0]       i_drawx,
  input  logic [9:0]       i_drawy,
  input  sprite_pos_t      i_pos,
  output logic             o_hit,
  output logic [OFF_W-1:0] o_dx,
  output logic [OFF_W-1:0] o_dy
);
  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;

  assign w_dx = {1'b0, i_drawx} - {1'b0, i_pos.x};
  assign w_dy = {1'b0, i_drawy} - {1'b0, i_pos.y};

  assign w_in_x = ~w_dx[10] & (w_dx < 11'(SPR_DIM));
  assign w_in_y = ~w_dy[10] & (w_dy < 11'(SPR_DIM));

  assign o_hit = i_pos.en & w_in_x & w_in_y;
  assign o_dx  = w_dx[OFF_W-1:0];
  assign o_dy  = w_dy[OFF_W-1:0];
endmodule

// File: rtl/sprite_index_gen.sv
// Sprite colour-index generator feeding the palette LUT.
// Two-stage pipeline around a synchronous sprite ROM.
module sprite_index_gen
  import sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic              frame_start,
  input  logic              pos_we,
  input  logic [SEL_W-1:0]  pos_sel,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              pos_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_data,
  output logic [IDX_W-1:0]  coloridx,
  output logic              idx_valid
);
  sprite_pos_t       r_shadow [NUM_SPR];
  sprite_pos_t       r_active [NUM_SPR];
  sprite_pos_t       w_shadow_nxt [NUM_SPR];

  logic [NUM_SPR-1:0] w_hit;
  logic [OFF_W-1:0]   w_dx [NUM_SPR];
  logic [OFF_W-1:0]   w_dy [NUM_SPR];
  logic [SEL_W-1:0]   w_sel;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;

  logic               r_s1_hit;
  logic               r_s1_valid;

  // Shadow write; a write in the commit cycle is seen by the commit
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (pos_we && (pos_sel == SEL_W'(i)))
        w_shadow_nxt[i] = {pos_en, pos_x, pos_y};
    end
  end

  // Shadow and active position registers, committed at frame start
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (frame_start)
          r_active[i] <= w_shadow_nxt[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_hit u_hit (
      .i_drawx (DrawX),
      .i_drawy (DrawY),
      .i_pos   (r_active[g]),
      .o_hit   (w_hit[g]),
      .o_dx    (w_dx[g]),
      .o_dy    (w_dy[g])
    );
  end

  // Lowest-index hit wins; with no hit sel stays 0
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_sel = SEL_W'(i);
        w_any = 1'b1;
      end
    end
  end

  // S0: register ROM address, hit flag and pixel valid
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr   <= '0;
      r_s1_hit   <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      rom_addr   <= {w_sel, w_dy[w_sel], w_dx[w_sel]};
      r_s1_hit   <= w_any;
      r_s1_valid <= pix_valid;
    end
  end

  // Transparent texels fall back to background, not lower sprites
  assign w_idx = (r_s1_valid && r_s1_hit && (rom_data != TRANSP))
               ? rom_data : BG_IDX;

  // S1: register palette index and its valid flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      coloridx  <= BG_IDX;
      idx_valid <= 1'b0;
    end else begin
      coloridx  <= w_idx;
      idx_valid <= r_s1_valid;
    end
  end
endmodule

// File: tb/tb_sprite_index_gen.sv
// Directed bench for sprite_index_gen.
// Behavioural ROM indexed by the registered rom_addr.
module tb_sprite_index_gen;
  logic        clk;
  logic        rst_n;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        pix_valid;
  logic        frame_start;
  logic        pos_we;
  logic [1:0]  pos_sel;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        pos_en;
  logic [11:0] rom_addr;
  logic [4:0]  rom_data;
  logic [4:0]  coloridx;
  logic        idx_valid;

  logic [4:0]  rom [4096];
  int          n_run;
  int          n_fail;

  sprite_index_gen dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .pos_we      (pos_we),
    .pos_sel     (pos_sel),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_en      (pos_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .coloridx    (coloridx),
    .idx_valid   (idx_valid)
  );

  assign rom_data = rom[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [9:0] x,
                    input logic [9:0] y, input logic en,
                    input logic fs);
    @(negedge clk);
    pos_we = 1'b1; pos_sel = s; pos_x = x; pos_y = y;
    pos_en = en; frame_start = fs;
    @(negedge clk);
    pos_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input logic [9:0] x,
                     input logic [9:0] y, input logic v,
                     input logic [11:0] ea, input logic [4:0] ei,
                     input logic ev);
    @(negedge clk);
    DrawX = x; DrawY = y; pix_valid = v;
    @(posedge clk); #1;
    chk({tag, ".addr"}, 32'(rom_addr), 32'(ea));
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".idx"}, 32'(coloridx), 32'(ei));
    chk({tag, ".vld"}, 32'(idx_valid), 32'(ev));
  endtask

  initial begin
    logic [15:0] vp;
    logic        prev;
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; DrawX = '0; DrawY = '0; pix_valid = 1'b0;
    frame_start = 1'b0; pos_we = 1'b0; pos_sel = '0;
    pos_x = '0; pos_y = '0; pos_en = 1'b0;
    for (int a = 0; a < 4096; a++)
      rom[a] = 5'h04 + 5'(a / 1024) * 5'd4;

    // 1: reset state, then streaming background
    #3;
    chk("rst.addr", 32'(rom_addr), 32'h0);
    chk("rst.idx", 32'(coloridx), 32'h0);
    chk("rst.vld", 32'(idx_valid), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); DrawX = 10; DrawY = 10; pix_valid = 1'b1;
    @(posedge clk); #1;
    chk("t1.vld_c1", 32'(idx_valid), 32'h0);
    @(posedge clk); #1;
    chk("t1.vld_c2", 32'(idx_valid), 32'h1);
    chk("t1.idx", 32'(coloridx), 32'h0);
    @(negedge clk); pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1.vld_hold", 32'(idx_valid), 32'h1);
    @(posedge clk); #1;
    chk("t1.blank", 32'(idx_valid), 32'h0);

    // 2: shadow write, then commit
    wr(2'd0, 10'd100, 10'd50, 1'b1, 1'b0);
    pix("t2.pre", 10'd100, 10'd50, 1'b1, 12'h244, 5'h00, 1'b1);
    commit();
    pix("t2.tl", 10'd100, 10'd50, 1'b1, 12'h000, 5'h04, 1'b1);
    pix("t2.br", 10'd131, 10'd81, 1'b1, 12'h3FF, 5'h04, 1'b1);
    pix("t2.rx", 10'd132, 10'd81, 1'b1, 12'h3E0, 5'h00, 1'b1);
    pix("t2.lx", 10'd99, 10'd50, 1'b1, 12'h01F, 5'h00, 1'b1);
    pix("t2.blk", 10'd100, 10'd50, 1'b0, 12'h000, 5'h00, 1'b0);

    // 3: priority and transparency
    wr(2'd0, 10'd200, 10'd200, 1'b1, 1'b0);
    wr(2'd1, 10'd200, 10'd200, 1'b1, 1'b0);
    commit();
    rom[0] = 5'h1F;
    pix("t3.tr", 10'd200, 10'd200, 1'b1, 12'h000, 5'h00, 1'b1);
    pix("t3.op", 10'd201, 10'd200, 1'b1, 12'h001, 5'h04, 1'b1);
    wr(2'd0, 10'd200, 10'd200, 1'b0, 1'b0);
    commit();
    pix("t3.s1", 10'd200, 10'd200, 1'b1, 12'h400, 5'h08, 1'b1);

    // 4: clipping at the screen edge and far-off sprite
    wr(2'd1, 10'd0, 10'd0, 1'b0, 1'b0);
    wr(2'd2, 10'd630, 10'd470, 1'b1, 1'b0);
    wr(2'd0, 10'd1000, 10'd1000, 1'b1, 1'b0);
    commit();
    pix("t4.e639", 10'd639, 10'd470, 1'b1, 12'h809, 5'h0C, 1'b1);
    pix("t4.e479", 10'd630, 10'd479, 1'b1, 12'h920, 5'h0C, 1'b1);
    pix("t4.l629", 10'd629, 10'd470, 1'b1, 12'h1CD, 5'h00, 1'b1);

    // 5: write in the commit cycle, then reset mid-line
    wr(2'd3, 10'd10, 10'd10, 1'b1, 1'b1);
    pix("t5.s3", 10'd10, 10'd10, 1'b1, 12'hC00, 5'h10, 1'b1);
    @(negedge clk); DrawX = 10; DrawY = 10; pix_valid = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    chk("t5.pre_idx", 32'(coloridx), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("t5.rst_idx", 32'(coloridx), 32'h0);
    chk("t5.rst_vld", 32'(idx_valid), 32'h0);
    chk("t5.rst_addr", 32'(rom_addr), 32'h0);
    @(negedge clk); rst_n = 1'b1; pix_valid = 1'b0;
    pix("t5.post", 10'd10, 10'd10, 1'b1, 12'h14A, 5'h00, 1'b1);

    // 6: alternating pix_valid
    vp = 16'hAAAA;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      DrawX = 10'(i); DrawY = 10'd300; pix_valid = vp[i];
      @(posedge clk); #1;
      chk($sformatf("t6.vld%0d", i), 32'(idx_valid), 32'(prev));
      prev = vp[i];
    end
    @(negedge clk); pix_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6.tail", 32'(idx_valid), 32'(prev));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
